// File: rtl/dbg_pkg.sv
// Shared constants for the debug dump framer: sync byte, frame geometry, FSM encoding.
package dbg_pkg;

    localparam logic [7:0]  DBG_SYNC_BYTE   = 8'hA5;
    localparam int unsigned DBG_FRAME_WORDS = 33;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_WORD = 3'd2;
    localparam logic [2:0] ST_SEL  = 3'd3;
    localparam logic [2:0] ST_CAPT = 3'd4;
    localparam logic [2:0] ST_CSUM = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

endpackage

// File: rtl/dbg_dump_uart_if.sv
// Core debug port: PC snapshot, register select out, register data back.
interface dbg_dump_uart_if;

    logic [31:0] dbg_pc;
    logic [31:0] dbg_reg_data;
    logic [4:0]  dbg_reg_sel;

    modport master (input dbg_pc, input dbg_reg_data, output dbg_reg_sel);
    modport slave  (output dbg_pc, output dbg_reg_data, input dbg_reg_sel);

endinterface

// File: rtl/dbg_dump_uart_tx.sv
// 8N1 UART transmitter; ready rises the cycle after the stop bit ends.
module uart_tx #(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    logic        active;
    logic [8:0]  shreg;
    logic [3:0]  bit_cnt;
    logic [15:0] div_cnt;

    assign ready = !active;

    // Bit sequencer: start bit on acceptance, then d0..d7 and stop, each CLK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            shreg   <= '1;
            bit_cnt <= '0;
            div_cnt <= '0;
            tx      <= 1'b1;
        end else if (!active) begin
            if (valid) begin
                active  <= 1'b1;
                shreg   <= {1'b1, data};
                bit_cnt <= '0;
                div_cnt <= '0;
                tx      <= 1'b0;
            end
        end else if (div_cnt == 16'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                active <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/dbg_dump_uart.sv
// Debug dump framer: sync, PC, x0..x31 and checksum streamed over UART 8N1.
module dbg_dump_uart
    import dbg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    dbg_dump_uart_if.master   dbg,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    logic [2:0]  state;
    logic [31:0] word_q;
    logic [5:0]  word_idx;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic        csum_sent;
    logic [4:0]  reg_sel;
    logic [7:0]  u_data;
    logic        u_valid;
    logic        u_ready;
    logic        accept;

    assign dbg.dbg_reg_sel = reg_sel;
    assign accept          = u_valid && u_ready;

    // Byte offered to the UART in the current state.
    always_comb begin
        u_data  = word_q[31:24];
        u_valid = 1'b0;
        case (state)
            ST_SYNC: begin
                u_data  = DBG_SYNC_BYTE;
                u_valid = 1'b1;
            end
            ST_WORD: u_valid = 1'b1;
            ST_CSUM: begin
                u_data  = csum;
                u_valid = !csum_sent;
            end
            default: u_valid = 1'b0;
        endcase
    end

    // Framing FSM, word shifter and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word_q    <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
            csum_sent <= 1'b0;
            reg_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        word_q    <= dbg.dbg_pc;
                        word_idx  <= '0;
                        byte_cnt  <= '0;
                        csum      <= '0;
                        csum_sent <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (accept) state <= ST_WORD;
                end
                ST_WORD: begin
                    if (accept) begin
                        word_q   <= {word_q[23:0], 8'h00};
                        csum     <= csum + word_q[31:24];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (word_idx == 6'(DBG_FRAME_WORDS - 1)) begin
                                state <= ST_CSUM;
                            end else begin
                                reg_sel <= word_idx[4:0];
                                state   <= ST_SEL;
                            end
                        end
                    end
                end
                ST_SEL: state <= ST_CAPT;
                ST_CAPT: begin
                    word_q   <= dbg.dbg_reg_data;
                    word_idx <= word_idx + 6'd1;
                    state    <= ST_WORD;
                end
                ST_CSUM: begin
                    // Hand-off first, then hold until the UART has shifted out the stop bit.
                    if (accept) begin
                        csum_sent <= 1'b1;
                    end else if (csum_sent && u_ready) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (u_data),
        .valid (u_valid),
        .ready (u_ready),
        .tx    (tx)
    );

endmodule

// File: tb/tb_dbg_dump_uart.sv
// Bench for dbg_dump_uart: wire-level frame reference built from the register model.
module tb_dbg_dump_uart;

    localparam int D  = 4;
    localparam int BL = 10 * D + 1;      // cycles per byte including one idle gap
    localparam int FL = 134 * BL + 1;    // sample index of done relative to frame start

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic tx, busy, done;

    dbg_dump_uart_if dbg ();

    dbg_dump_uart #(.CLK_DIV(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .dbg   (dbg),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Core register model; in poison mode a read is only valid exactly 2 edges after a select change.
    logic [31:0] regs [32];
    logic        poison   = 1'b0;
    logic [4:0]  sel_prev = '0;
    int          age      = 0;

    always @(posedge clk) begin
        if (dbg.dbg_reg_sel != sel_prev) age <= 0;
        else age <= age + 1;
        sel_prev <= dbg.dbg_reg_sel;
    end

    assign dbg.dbg_reg_data = (!poison || (dbg.dbg_reg_sel == sel_prev && age == 0))
                              ? regs[dbg.dbg_reg_sel] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic       txq[$];
    logic       doneq[$];
    logic       busyq[$];
    int         selq[$];
    logic [4:0] sel_last;
    logic [7:0] expb[$];

    task automatic clear_log();
        txq.delete();
        doneq.delete();
        busyq.delete();
        selq.delete();
        sel_last = dbg.dbg_reg_sel;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            txq.push_back(tx);
            doneq.push_back(done);
            busyq.push_back(busy);
            if (dbg.dbg_reg_sel != sel_last) begin
                selq.push_back(int'(dbg.dbg_reg_sel));
                sel_last = dbg.dbg_reg_sel;
            end
        end
    endtask

    // Reference frame: sync, then PC and x0..x31 MSB first, then byte sum of the data bytes.
    task automatic build_frame(input logic [31:0] pc);
        int          sum = 0;
        logic [31:0] w;
        logic [7:0]  b;
        expb.delete();
        expb.push_back(8'hA5);
        for (int wi = 0; wi < 33; wi++) begin
            w = (wi == 0) ? pc : regs[wi - 1];
            for (int k = 3; k >= 0; k--) begin
                b = 8'((w >> (8 * k)) & 32'hFF);
                expb.push_back(b);
                sum = sum + int'(b);
            end
        end
        expb.push_back(8'(sum % 256));
    endtask

    task automatic check_frame(input string tag, input int o);
        logic [63:0] obs, exp;
        logic [7:0]  bb;
        int          bitn, dc;
        chk({tag, " idle_before"}, 64'(txq[o]), 64'd1);
        chk({tag, " busy_first"}, 64'(busyq[o]), 64'd1);
        for (int b = 0; b < 134; b++) begin
            obs = '0;
            exp = '0;
            bb  = expb[b];
            for (int k = 0; k < BL; k++) begin
                obs[k] = txq[o + 1 + b * BL + k];
                bitn   = k / D;
                if (k == BL - 1)   exp[k] = 1'b1;
                else if (bitn == 0) exp[k] = 1'b0;
                else if (bitn == 9) exp[k] = 1'b1;
                else                exp[k] = bb[bitn - 1];
            end
            chk($sformatf("%s byte%0d", tag, b), obs, exp);
        end
        dc = 0;
        for (int i = o; i <= o + FL; i++) dc += int'(doneq[i]);
        chk({tag, " done_count"}, 64'(dc), 64'd1);
        chk({tag, " done_pos"}, 64'(doneq[o + FL]), 64'd1);
        chk({tag, " busy_at_done"}, 64'(busyq[o + FL]), 64'd0);
        chk({tag, " busy_before_done"}, 64'(busyq[o + FL - 1]), 64'd1);
    endtask

    task automatic check_sel(input string tag, input int first);
        chk({tag, " sel_steps"}, 64'(selq.size()), 64'(32 - first));
        for (int i = 0; i < selq.size(); i++)
            chk($sformatf("%s sel%0d", tag, i), 64'(selq[i]), 64'(i + first));
    endtask

    task automatic rand_regs();
        regs[0] = '0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
    endtask

    // One frame; PC is scrambled right after acceptance, optional start pulse mid-frame.
    task automatic frame_single(input string tag, input logic [31:0] pc, input logic pois,
                                input int first, input logic pulse);
        int lows, dc;
        dbg.dbg_pc = pc;
        poison = pois;
        build_frame(pc);
        clear_log();
        @(negedge clk);
        start = 1'b1;
        capture(1);
        start = 1'b0;
        dbg.dbg_pc = ~pc;
        if (pulse) begin
            capture(2000);
            start = 1'b1;
            capture(1);
            start = 1'b0;
        end
        capture(FL + 61 - txq.size());
        check_frame(tag, 0);
        check_sel(tag, first);
        lows = 0;
        for (int i = FL + 1; i < txq.size(); i++) lows += int'(!txq[i]);
        chk({tag, " tail_idle"}, 64'(lows), 64'd0);
        dc = 0;
        for (int i = 0; i < doneq.size(); i++) dc += int'(doneq[i]);
        chk({tag, " frames"}, 64'(dc), 64'd1);
    endtask

    initial begin
        int lows, dc;
        logic [31:0] pc;

        dbg.dbg_pc = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst tx", 64'(tx), 64'd1);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst sel", 64'(dbg.dbg_reg_sel), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            lows += int'(!tx) + int'(busy) + int'(done);
        end
        chk("idle_1000", 64'(lows), 64'd0);

        // Basic frame with the ramp register pattern.
        regs[0] = '0;
        for (int i = 1; i < 32; i++) regs[i] = 32'h1100_0000 + 32'(i);
        frame_single("basic", 32'h0000_0040, 1'b0, 1, 1'b0);

        // Random contents, strict 2-edge sampling window.
        rand_regs();
        frame_single("rand", $urandom, 1'b1, 0, 1'b0);

        // All ones: 132 x 0xFF, sum wraps.
        for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
        frame_single("allff", 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        chk("allff csum", 64'(expb[133]), 64'h7C);

        // Start pulse while busy is ignored.
        rand_regs();
        frame_single("pulse", $urandom, 1'b1, 0, 1'b1);

        // Start held high: two contiguous frames.
        rand_regs();
        pc = $urandom;
        dbg.dbg_pc = pc;
        poison = 1'b1;
        build_frame(pc);
        clear_log();
        @(negedge clk);
        start = 1'b1;
        capture(FL + 4);
        start = 1'b0;
        capture(FL + 60);
        check_frame("b2b0", 0);
        check_frame("b2b1", FL + 2);
        chk("b2b gap1", 64'(txq[FL + 1]), 64'd1);
        dc = 0;
        for (int i = 0; i < doneq.size(); i++) dc += int'(doneq[i]);
        chk("b2b frames", 64'(dc), 64'd2);

        // Reset during byte 50's start bit.
        rand_regs();
        pc = $urandom;
        dbg.dbg_pc = pc;
        clear_log();
        @(negedge clk);
        start = 1'b1;
        capture(1);
        start = 1'b0;
        capture(50 * BL + 1);
        chk("mid start_bit", 64'(tx), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid tx", 64'(tx), 64'd1);
        chk("mid busy", 64'(busy), 64'd0);
        chk("mid sel", 64'(dbg.dbg_reg_sel), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rand_regs();
        frame_single("post_rst", $urandom, 1'b0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbg_dump_uart.md
# dbg_dump_uart

Debug-bus reader that sits beside `core` in `toplevel`. On request it walks the core's register-file debug port (`dbg_reg_sel` out, `dbg_reg_data` in), snapshots `dbg_pc`, and streams one framed, checksummed dump over a UART 8N1 transmit line. It gives a board-level view of architectural state without a JTAG/ILA.

## Interface
- `CLK_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range 4..65535.
- `clk`  in  1  system clock; same clock as `core`.
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  level request; sampled only in IDLE.
- `dbg_pc`  in  32  core program counter.
- `dbg_reg_data`  in  32  register value for the current `dbg_reg_sel`; combinational in core.
- `dbg_reg_sel`  out  5  register index driven to core.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high from frame acceptance until `done`.
- `done`  out  1  one-cycle pulse after the checksum stop bit completes.

## Operation
- Frame: 134 bytes.
  - `0xA5` sync.
  - PC as 4 bytes, MSB first.
  - x0..x31, each 4 bytes MSB first.
  - Checksum: 8-bit sum mod 256 of the 132 data bytes. Sync byte excluded.
- FSM states: IDLE, SYNC, WORD, SEL, CAPT, CSUM, DONE.
  - IDLE: `start`=1 → latch `dbg_pc` into `word_q`, set `word_idx`=0, `csum`=0 → SYNC.
  - SYNC: present `0xA5` until accepted → WORD.
  - WORD: present `word_q[31:24]`. On each acceptance, shift `word_q` left by 8 and add the byte to `csum`.
  - After the 4th byte of a word:
    - `word_idx`==32 → CSUM.
    - Otherwise drive `dbg_reg_sel`=`word_idx[4:0]` → SEL.
  - SEL: one settle cycle → CAPT.
  - CAPT: `word_q` ← `dbg_reg_data`, `word_idx`++ → WORD.
  - CSUM: present `csum` until accepted, wait for UART ready → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- The PC is snapshotted at acceptance. Each register is sampled in its own CAPT cycle; a running core may therefore yield a non-atomic dump.
- `start` asserted while `busy` is ignored. `start` held high produces back-to-back frames.
- `dbg_reg_sel` holds its last value (31) after a frame, and returns to 0 on reset only.
- Arithmetic: `csum` is 8 bits with natural wrap. `word_idx` is 6 bits.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `dbg_reg_sel`=0. FSM and UART go to idle.
- Reset is asynchronous: `tx` returns high without waiting for a clock edge. A partial frame is truncated, never resumed.
- `start` seen high at edge N:
  - `busy`=1 after N.
  - UART accepts the sync byte at N+1.
  - `tx` low (start bit) after N+1.
- Each bit lasts exactly `CLK_DIV` cycles.
- Byte order on the wire: start(0), d0..d7 LSB first, stop(1).
- Inter-byte gap: exactly 1 idle-high cycle between a stop bit and the next start bit, including word boundaries. SEL+CAPT (2 cycles) overlap the previous byte's transmission, which is why `CLK_DIV`≥4 is required.
- `dbg_reg_data` is sampled exactly 2 edges after `dbg_reg_sel` changes.
- `done` pulses the cycle after the checksum stop bit ends. `busy` falls on the same edge.
- Frame length: 134·(10·`CLK_DIV`+1) + 2 cycles, ±1.

## Structure
- Shared package/header `dbg_pkg`:
  - `DBG_SYNC_BYTE`=8'hA5
  - `DBG_FRAME_WORDS`=33
  - FSM state encoding
- Sub-module `uart_tx`:
  - Ports: `clk`, `rst_n`, `data[7:0]`, `valid`, `ready`, `tx`; parameter `CLK_DIV`.
  - Byte accepted on `valid`&&`ready`.
  - `ready` drops after acceptance and rises the cycle after the stop bit ends.
- `dbg_dump_uart` holds the framing FSM, word shifter and checksum.

## Test plan
- Reset:
  - With `rst_n`=0 → `tx`=1, `busy`=0, `done`=0, `dbg_reg_sel`=0.
  - Releasing reset with `start`=0 → line stays high for 1000 cycles.
- Basic frame:
  - Setup: `CLK_DIV`=4, `dbg_pc`=0x0000_0040, reg model xi=0x1100_0000+i (x0=0).
  - Decoded frame: A5, 00 00 00 40, 00 00 00 00, 11 00 00 01 … 11 00 00 1F, then the reference checksum.
  - `done` pulses once.
- Bit timing (`CLK_DIV`=4):
  - Every start/data/stop bit is 4 cycles.
  - Gaps are exactly 1 cycle.
  - `dbg_reg_sel` steps 0..31 in order, each sample 2 edges after the change.
- Checksum wrap: `dbg_pc` and all regs 0xFFFF_FFFF → 132 bytes of 0xFF, checksum 0x7C.
- Start handling:
  - `start` pulsed during `busy` → ignored; exactly one frame.
  - `start` held high → two contiguous frames, the second sync byte starting 2 cycles after `done`.
- Reset mid-frame:
  - `rst_n` low during byte 50 → `tx`=1 and `busy`=0 asynchronously.
  - Subsequent `start` → complete, correct frame beginning with A5.
